ras_ctrl: RTL
=============

Name: ras_ctrl

Overview:
- Companion controller for the return address stack (RAS) in the IF branch unit.
- Fetch side: predecodes each fetched MIPS instruction and drives the RAS push/pop/push-address inputs. It also records the RAS-predicted return target in an in-order pending queue.
- Resolve side: checks each executed JR $ra against the queue head. It drives the RAS correction inputs and raises a flush with a redirect PC on a mispredicted return.

Parameters:
- PEND_DEPTH, 4, entries in the pending-return queue (power of 2, ≥2).

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  synchronous reset, active-low (0 = reset).
- inst_valid_i  in  1  fetched instruction valid.
- inst_pc_i  in  32  PC of fetched instruction.
- inst_i  in  32  fetched instruction word.
- stall_o  out  1  pending queue full; fetch must hold the current return instruction.
- ras_push_o  out  1  to RAS push.
- ras_pop_o  out  1  to RAS pop.
- ras_push_addr_o  out  32  to RAS push address (inst_pc_i+8).
- ras_target_i  in  32  RAS branch-address output.
- ex_valid_i  in  1  execute-stage resolved branch valid.
- ex_pc_i  in  32  PC of the resolved branch.
- ex_is_call_i  in  1  resolved instruction writes $31 (JAL/JALR/BGEZAL/BLTZAL).
- ex_is_return_i  in  1  resolved instruction is JR with rs=31.
- ex_target_i  in  32  actual jump target.
- pipe_flush_i  in  1  external flush (exception/eret).
- flush_o  out  1  return mispredict flush, to RAS fllush and fetch.
- redirect_pc_o  out  32  correct target when flush_o=1.
- corr_addr_o  out  32  to RAS correction address (ex_pc_i, registered).
- corr_link_o  out  1  to RAS correction link flag.
- corr_return_o  out  1  to RAS correction return flag.

Behaviour:
- Predecode (combinational, on inst_i):
  - Call: opcode 000011; or opcode 000000 with funct 001001; or opcode 000001 with rt 10000/10001.
  - Return: opcode 000000, funct 001000, rs 11111.
  - JALR with rs=31 counts as call only.
- Fetch enable: fe = inst_valid_i & ~stall_o & ~flush_o & ~pipe_flush_i.
- ras_push_o = fe & call. ras_pop_o = fe & return. ras_push_addr_o = inst_pc_i+8, mod 2^32 (wraps).
- Target capture: the RAS presents the predicted target one cycle after the pop.
  - A pop sets pop_d1. On the next cycle, if pop_d1 and no flush, ras_target_i is enqueued.
- Queue: FIFO, PEND_DEPTH entries, occupancy counter 0..PEND_DEPTH.
  - Reserved count = occupancy + pop_d1.
  - stall_o = (reserved count == PEND_DEPTH) & return decoded & inst_valid_i.
  - Enqueue and dequeue in the same cycle is allowed; occupancy is unchanged.
  - Pointers wrap modulo PEND_DEPTH.
- Resolve (registered, 1-cycle latency):
  - Each ex_valid_i cycle registers corr_addr_o = ex_pc_i, corr_link_o = ex_is_call_i, corr_return_o = ex_is_return_i.
  - Without ex_valid_i, the corr flags register to 0.
- Return check, when ex_valid_i & ex_is_return_i:
  - Dequeue the head.
  - If the queue is empty (and no same-cycle enqueue bypass) or head ≠ ex_target_i: next cycle flush_o=1 for exactly 1 cycle, with redirect_pc_o = ex_target_i.
  - Head equal to ex_target_i: no flush.
  - Same-cycle enqueue into an empty queue is bypassed and compared directly.
- On flush_o=1 or pipe_flush_i=1:
  - Next cycle: occupancy=0, pointers=0, pop_d1=0.
  - The corr_* outputs of that resolve are still emitted; the RAS uses them to rebuild.
- pipe_flush_i has priority over the return check: no flush_o is generated in a pipe_flush_i cycle.
- Reset (rst=0, sync):
  - flush_o=0, redirect_pc_o=0, corr_addr_o=0, corr_link_o=0, corr_return_o=0.
  - Queue empty, pop_d1=0, stall_o=0.
  - Reset mid-operation discards all pending entries.
  - ras_push_o/ras_pop_o are forced 0 while rst=0.

Test Plan:
- Call/return match: fetch JAL at 0x0000_1000 → ras_push_o=1, addr 0x0000_1008. Fetch JR $ra, RAS target 0x0000_1008; execute returns to 0x0000_1008 → ras_pop_o=1, one queue entry, no flush_o, corr_return_o=1 one cycle after ex_valid_i.
- Mispredict: queued target 0x0000_1008, ex_target_i=0x0000_2000 → flush_o=1 for 1 cycle, redirect_pc_o=0x0000_2000, queue empty, next fetched return not suppressed.
- Queue full: PEND_DEPTH=4, four unresolved returns fetched, fifth return presented → stall_o=1, no pop. Resolve one return → stall_o=0 next cycle, fifth pop issued.
- Empty-queue return: execute JR $ra with no pending entry → flush_o=1, redirect_pc_o=ex_target_i.
- Simultaneous events: enqueue and matching dequeue in the same cycle → occupancy unchanged. pipe_flush_i with a mismatching return → no flush_o, queue cleared, corr_* still emitted.
- Reset mid-run: rst=0 with 3 entries pending and flush_o pending → all outputs 0 next cycle, queue empty, ras_pop_o=0 while in reset.
- Wrap: JAL at 0xFFFF_FFF8 → ras_push_addr_o=0x0000_0000.

Source files
------------

// File: rtl/ras_ctrl.sv
// ras_ctrl: RAS push/pop predecode, pending-return queue and return-mispredict flush.
module ras_ctrl #(
    parameter int PEND_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_valid_i,
    input  logic [31:0] inst_pc_i,
    input  logic [31:0] inst_i,
    output logic        stall_o,
    output logic        ras_push_o,
    output logic        ras_pop_o,
    output logic [31:0] ras_push_addr_o,
    input  logic [31:0] ras_target_i,
    input  logic        ex_valid_i,
    input  logic [31:0] ex_pc_i,
    input  logic        ex_is_call_i,
    input  logic        ex_is_return_i,
    input  logic [31:0] ex_target_i,
    input  logic        pipe_flush_i,
    output logic        flush_o,
    output logic [31:0] redirect_pc_o,
    output logic [31:0] corr_addr_o,
    output logic        corr_link_o,
    output logic        corr_return_o
);
    localparam int AW = $clog2(PEND_DEPTH);
    localparam int CW = AW + 1;

    logic [5:0]    op, funct;
    logic [4:0]    rs, rt;
    logic          is_call, is_ret, fe, enq, chk, empty, bypass, deq, enq_w, mis, clr, unused;
    logic [31:0]   head;
    logic [31:0]   mem_q [PEND_DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0] occ_q, occ_d;
    logic          pop_d1_q, pop_d1_d, flush_q, flush_d, link_q, link_d, ret_q, ret_d;
    logic [31:0]   redir_q, redir_d, corr_addr_q, corr_addr_d;

    assign op     = inst_i[31:26];
    assign rs     = inst_i[25:21];
    assign rt     = inst_i[20:16];
    assign funct  = inst_i[5:0];
    assign unused = ^inst_i[15:6];

    assign is_call = (op == 6'b000011) | (op == 6'b000000 & funct == 6'b001001)
                   | (op == 6'b000001 & (rt == 5'b10000 | rt == 5'b10001));
    assign is_ret  = op == 6'b000000 & funct == 6'b001000 & rs == 5'b11111;

    // A pop still waiting for its target already owns a queue slot.
    assign stall_o = rst & inst_valid_i & is_ret & (occ_q + CW'(pop_d1_q) == CW'(PEND_DEPTH));
    assign fe      = rst & inst_valid_i & ~stall_o & ~flush_q & ~pipe_flush_i;

    assign ras_push_o      = fe & is_call;
    assign ras_pop_o       = fe & is_ret;
    assign ras_push_addr_o = inst_pc_i + 32'd8;

    assign clr    = flush_q | pipe_flush_i;
    assign enq    = pop_d1_q & ~clr;
    assign chk    = ex_valid_i & ex_is_return_i;
    assign empty  = occ_q == '0;
    assign bypass = chk & empty & enq;
    assign head   = empty ? ras_target_i : mem_q[rd_q];
    assign mis    = chk & ~pipe_flush_i & ((empty & ~enq) | head != ex_target_i);
    assign deq    = chk & ~empty;
    assign enq_w  = enq & ~bypass;

    always_comb begin
        occ_d       = clr ? '0 : occ_q + CW'(enq_w) - CW'(deq);
        wr_d        = clr ? '0 : wr_q + AW'(enq_w);
        rd_d        = clr ? '0 : rd_q + AW'(deq);
        pop_d1_d    = ras_pop_o;
        flush_d     = mis;
        redir_d     = mis ? ex_target_i : redir_q;
        corr_addr_d = ex_valid_i ? ex_pc_i : corr_addr_q;
        link_d      = ex_valid_i & ex_is_call_i;
        ret_d       = ex_valid_i & ex_is_return_i;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            occ_q       <= '0;
            wr_q        <= '0;
            rd_q        <= '0;
            pop_d1_q    <= 1'b0;
            flush_q     <= 1'b0;
            redir_q     <= '0;
            corr_addr_q <= '0;
            link_q      <= 1'b0;
            ret_q       <= 1'b0;
        end else begin
            occ_q       <= occ_d;
            wr_q        <= wr_d;
            rd_q        <= rd_d;
            pop_d1_q    <= pop_d1_d;
            flush_q     <= flush_d;
            redir_q     <= redir_d;
            corr_addr_q <= corr_addr_d;
            link_q      <= link_d;
            ret_q       <= ret_d;
            if (enq_w) mem_q[wr_q] <= ras_target_i;
        end
    end

    assign flush_o       = flush_q;
    assign redirect_pc_o = redir_q;
    assign corr_addr_o   = corr_addr_q;
    assign corr_link_o   = link_q;
    assign corr_return_o = ret_q;
endmodule
